sw_debounce: RTL and testbench

//   Input conditioning stage between the board slide switches and the LED PWM

---
 rtl/sw_debounce.sv | 104 ++++++++++
 tb/tb_sw_debounce.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// sw_debounce: synchronises a bus of slide switches into clk, accepts a new
// level per channel only after it has persisted across STABLE_TICKS sample
// ticks, and emits one-cycle rise/fall events on each accepted change.

// One debounce channel: 2-flop synchroniser, tick counter, clean level, events.
module sw_debounce_lane #(
    parameter int STABLE_TICKS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);
    localparam int CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS - 1);

    logic             sync1;
    logic             s;
    logic [CNT_W-1:0] cnt;

    // Two-stage synchroniser; nothing filters the raw pin before this.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
        end
    end

    // Count ticks while the synchronised level disagrees with the clean
    // level; any agreeing cycle (even between ticks) restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (s == clean) begin
                cnt <= '0;
            end else if (tick && (cnt == CNT_MAX)) begin
                clean <= s;
                cnt   <= '0;
                rise  <= s;
                fall  <= ~s;
            end else if (tick) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// Top: shared sample-tick prescaler feeding WIDTH independent channels.
module sw_debounce #(
    parameter int WIDTH        = 16,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             tick
);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div;

    // Prescaler: tick is registered off the terminal count, so it is high for
    // exactly one cycle in every TICK_DIV (every cycle when TICK_DIV is 1).
    always_ff @(posedge clk) begin
        if (rst) begin
            div  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (div == DIV_MAX);
            div  <= (div == DIV_MAX) ? '0 : div + DIV_W'(1);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        sw_debounce_lane #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .raw   (sw_raw[i]),
            .clean (sw_clean[i]),
            .rise  (sw_rise[i]),
            .fall  (sw_fall[i])
        );
    end
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: scenario tasks plus randomized traffic, checked against a
// history-based reference model of the debounce acceptance rule.
module tb_sw_debounce;
    localparam int W  = 16;
    localparam int TD = 4;
    localparam int ST = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw_raw = '1;
    logic [W-1:0] sw_clean, sw_rise, sw_fall;
    logic         tick;

    int n_checks = 0;
    int n_pass   = 0;

    sw_debounce #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_raw   (sw_raw),
        .sw_clean (sw_clean),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    // Reference model. k numbers the posedges since reset release (1 = first).
    // rawh[k] is the raw bus seen at edge k; the synchronised value seen at
    // edge k is the raw bus from two edges earlier. A tick is seen at edge k
    // when k-1 is a positive multiple of TD. A bit flips at a tick edge when
    // its current mismatch run (counted back through history) holds ST ticks.
    int           k = 0;
    logic [W-1:0] rawh [0:16383];
    logic [W-1:0] m_clean = '0, m_rise = '0, m_fall = '0;
    logic         m_tick = 1'b0;

    function automatic logic [W-1:0] s_at(int j);
        if (j >= 3) return rawh[j-2];
        return '0;
    endfunction

    function automatic bit tick_at(int j);
        return (j > 1) && (((j - 1) % TD) == 0);
    endfunction

    always @(posedge clk) begin : model
        logic [W-1:0] prev, nxt, sj;
        int           n;
        if (rst) begin
            k = 0; m_clean = '0; m_rise = '0; m_fall = '0; m_tick = 1'b0;
        end else begin
            if (k < 16383) k++;
            rawh[k] = sw_raw;
            prev = m_clean;
            nxt  = prev;
            if (tick_at(k)) begin
                for (int b = 0; b < W; b++) begin
                    n = 0;
                    for (int j = k; j >= 1; j--) begin
                        sj = s_at(j);
                        if (sj[b] == prev[b]) break;
                        if (tick_at(j)) n++;
                    end
                    if (n == ST) nxt[b] = ~prev[b];
                end
            end
            m_rise  = nxt & ~prev;
            m_fall  = ~nxt & prev;
            m_clean = nxt;
            m_tick  = ((k % TD) == 0);
        end
    end

    task automatic test_reset();
        rst = 1'b1; sw_raw = '1;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if ({sw_clean, sw_rise, sw_fall, tick} !== '0)
                $display("FAIL reset_hold got clean=%h rise=%h fall=%h tick=%b exp all 0", sw_clean, sw_rise, sw_fall, tick);
            else n_pass++;
        end
        rst = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 21) sw_raw = '0;
            @(negedge clk);
            if (c == 1) begin
                n_checks++;
                if ({sw_clean, sw_rise, sw_fall, tick} !== '0)
                    $display("FAIL reset_after got clean=%h rise=%h fall=%h tick=%b exp all 0", sw_clean, sw_rise, sw_fall, tick);
                else n_pass++;
            end
            if (c <= 6) begin
                n_checks++;
                if (tick !== (c == 4)) $display("FAIL reset_tick c=%0d got %b exp %b", c, tick, (c == 4));
                else n_pass++;
            end
            n_checks++;
            if ({sw_clean, sw_rise, sw_fall, tick} !== {m_clean, m_rise, m_fall, m_tick})
                $display("FAIL reset_model c=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", c, sw_clean, sw_rise, sw_fall, tick, m_clean, m_rise, m_fall, m_tick);
            else n_pass++;
        end
        n_checks++;
        if (sw_clean !== '0) $display("FAIL reset_settle got %h exp 0000", sw_clean);
        else n_pass++;
    endtask

    task automatic test_clean_edge();
        int found = 0, nrise = 0, rise_c = 0;
        bit fell = 0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        sw_raw = 16'h0001;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (found == 0 && sw_clean[0]) found = c;
            if (sw_rise[0]) begin nrise++; rise_c = c; end
            if (sw_fall !== '0) fell = 1;
            n_checks++;
            if ({sw_clean, sw_rise, sw_fall, tick} !== {m_clean, m_rise, m_fall, m_tick})
                $display("FAIL edge_model c=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", c, sw_clean, sw_rise, sw_fall, tick, m_clean, m_rise, m_fall, m_tick);
            else n_pass++;
        end
        n_checks++;
        if (found < 11 || found > 14) $display("FAIL edge_latency got %0d exp 11..14", found);
        else n_pass++;
        n_checks++;
        if (nrise != 1 || rise_c != found) $display("FAIL edge_rise got count=%0d at %0d exp 1 at %0d", nrise, rise_c, found);
        else n_pass++;
        n_checks++;
        if (fell) $display("FAIL edge_fall got pulse exp none");
        else n_pass++;
    endtask

    task automatic test_bounce();
        bit disturbed = 0;
        int found = 0, nrise = 0;
        sw_raw = 16'h0001;
        for (int t = 0; t < 60; t++) begin
            if (t % 5 == 0) sw_raw[3] = ~sw_raw[3];
            @(negedge clk);
            if (sw_clean[3] || sw_rise[3] || sw_fall[3]) disturbed = 1;
            n_checks++;
            if ({sw_clean, sw_rise, sw_fall, tick} !== {m_clean, m_rise, m_fall, m_tick})
                $display("FAIL bounce_model t=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", t, sw_clean, sw_rise, sw_fall, tick, m_clean, m_rise, m_fall, m_tick);
            else n_pass++;
        end
        n_checks++;
        if (disturbed) $display("FAIL bounce_quiet got change on bit3 exp none");
        else n_pass++;
        sw_raw[3] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (found == 0 && sw_clean[3]) found = c;
            if (sw_rise[3]) nrise++;
            n_checks++;
            if ({sw_clean, sw_rise, sw_fall, tick} !== {m_clean, m_rise, m_fall, m_tick})
                $display("FAIL bounce_hold_model c=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", c, sw_clean, sw_rise, sw_fall, tick, m_clean, m_rise, m_fall, m_tick);
            else n_pass++;
        end
        n_checks++;
        if (found < 11 || found > 14 || nrise != 1) $display("FAIL bounce_settle got latency=%0d rises=%0d exp 11..14 and 1", found, nrise);
        else n_pass++;
    endtask

    task automatic test_release();
        int found = 0, nfall = 0;
        sw_raw = 16'h00FF;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            n_checks++;
            if ({sw_clean, sw_rise, sw_fall, tick} !== {m_clean, m_rise, m_fall, m_tick})
                $display("FAIL release_pre_model c=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", c, sw_clean, sw_rise, sw_fall, tick, m_clean, m_rise, m_fall, m_tick);
            else n_pass++;
        end
        n_checks++;
        if (sw_clean !== 16'h00FF) $display("FAIL release_pre got %h exp 00ff", sw_clean);
        else n_pass++;
        sw_raw = 16'h0000;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (sw_fall !== '0) nfall++;
            if (found == 0 && sw_clean !== 16'h00FF) begin
                found = c;
                n_checks++;
                if (sw_clean !== 16'h0000 || sw_fall !== 16'h00FF || sw_rise !== 16'h0000)
                    $display("FAIL release_edge got clean=%h fall=%h rise=%h exp 0000/00ff/0000", sw_clean, sw_fall, sw_rise);
                else n_pass++;
            end
            n_checks++;
            if ({sw_clean, sw_rise, sw_fall, tick} !== {m_clean, m_rise, m_fall, m_tick})
                $display("FAIL release_model c=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", c, sw_clean, sw_rise, sw_fall, tick, m_clean, m_rise, m_fall, m_tick);
            else n_pass++;
        end
        n_checks++;
        if (found < 11 || found > 14 || nfall != 1) $display("FAIL release_latency got %0d falls=%0d exp 11..14 and 1", found, nfall);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int found = 0;
        sw_raw = 16'h0020;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            n_checks++;
            if ({sw_clean, sw_rise, sw_fall, tick} !== {m_clean, m_rise, m_fall, m_tick})
                $display("FAIL midrst_pre_model c=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", c, sw_clean, sw_rise, sw_fall, tick, m_clean, m_rise, m_fall, m_tick);
            else n_pass++;
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({sw_clean, sw_rise, sw_fall, tick} !== '0)
            $display("FAIL midrst_hold got %h/%h/%h/%b exp all 0", sw_clean, sw_rise, sw_fall, tick);
        else n_pass++;
        rst = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (found == 0 && sw_clean[5]) found = c;
            n_checks++;
            if ({sw_clean, sw_rise, sw_fall, tick} !== {m_clean, m_rise, m_fall, m_tick})
                $display("FAIL midrst_model c=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", c, sw_clean, sw_rise, sw_fall, tick, m_clean, m_rise, m_fall, m_tick);
            else n_pass++;
        end
        n_checks++;
        if (found < 11 || found > 14) $display("FAIL midrst_latency got %0d exp 11..14", found);
        else n_pass++;
    endtask

    task automatic test_independence();
        int found = 0, hold = 0;
        bit both = 0;
        sw_raw = '0;
        repeat (16) @(negedge clk);
        sw_raw[1] = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            if (hold == 0) begin
                sw_raw[2] = ~sw_raw[2];
                hold = int'($urandom_range(1, 3));
            end
            hold--;
            @(negedge clk);
            if (found == 0 && sw_clean[1]) found = c;
            if ((sw_rise & sw_fall) !== '0) both = 1;
            n_checks++;
            if ({sw_clean, sw_rise, sw_fall, tick} !== {m_clean, m_rise, m_fall, m_tick})
                $display("FAIL indep_model c=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", c, sw_clean, sw_rise, sw_fall, tick, m_clean, m_rise, m_fall, m_tick);
            else n_pass++;
        end
        n_checks++;
        if (found < 11 || found > 14) $display("FAIL indep_latency got %0d exp 11..14", found);
        else n_pass++;
        n_checks++;
        if (sw_clean[2] !== 1'b0 || both) $display("FAIL indep_bounce got clean2=%b both=%b exp 0/0", sw_clean[2], both);
        else n_pass++;
        sw_raw[2] = 1'b0;
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 1; c <= 400; c++) begin
            if (hold == 0) begin
                sw_raw = W'($urandom);
                hold = int'($urandom_range(1, 16));
            end
            hold--;
            @(negedge clk);
            n_checks++;
            if ({sw_clean, sw_rise, sw_fall, tick} !== {m_clean, m_rise, m_fall, m_tick})
                $display("FAIL random_model c=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", c, sw_clean, sw_rise, sw_fall, tick, m_clean, m_rise, m_fall, m_tick);
            else n_pass++;
            n_checks++;
            if ((sw_rise & sw_fall) !== '0) $display("FAIL random_both c=%0d got %h exp 0000", c, sw_rise & sw_fall);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_edge();
        test_bounce();
        test_release();
        test_reset_mid();
        test_independence();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "timeout");
    end
endmodule
